// File: rtl/sort_pkg.sv
// -----------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the 8-entry sorter front end.
//   SORT_DW  : sample width in bits (matches the sorter's x1..x8 inputs)
//   SORT_N   : samples per frame
//   state_t  : frame collector FSM state (FILL / HOLD)
//   frame_t  : one assembled frame, element k = k-th sample in arrival order
// -----------------------------------------------------------------------------
package sort_pkg;

  localparam int SORT_DW = 4;
  localparam int SORT_N  = 8;

  // FILL: staging register is collecting samples.
  // HOLD: staging holds a complete frame waiting for the output register.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef logic [SORT_N-1:0][SORT_DW-1:0] frame_t;

endpackage

// File: rtl/sort_frame_collector.sv
// -----------------------------------------------------------------------------
// sort_frame_collector
// Collects a serial stream of DW-bit samples into N-sample frames for the
// combinational sorter. Double-buffered: a staging register assembles the next
// frame while the output register presents the previous one, so a continuous
// input stream runs at one sample per cycle as long as the consumer keeps up.
//
// Ports
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   upstream sample valid
//   in_ready     out  collector can take a sample this cycle
//   in_data      in   sample value [DW-1:0]
//   in_flush     in   discard the partially assembled frame (FILL only)
//   frame_valid  out  complete frame present on frame_data
//   frame_ready  in   consumer takes the frame
//   frame_data   out  packed frame [N*DW-1:0]; sample k at [k*DW +: DW]
//   frame_cnt    out  frames handed off, wraps modulo 256
//
// Handshakes: a beat moves on a rising edge where valid && ready are both 1.
// A valid source holds its payload stable until that edge; ready never
// depends on the same interface's valid (in_ready is a function of the FSM
// state and in_flush only).
// The FSM state is kept in state_q so checkers can bind to it directly.
// -----------------------------------------------------------------------------
import sort_pkg::*;

module sort_frame_collector #(
  parameter int DW = SORT_DW,
  parameter int N  = SORT_N
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic            in_flush,
  output logic            frame_valid,
  input  logic            frame_ready,
  output logic [N*DW-1:0] frame_data,
  output logic [7:0]      frame_cnt
);

  localparam int            IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t                state_q;
  state_t                state_d;
  logic [IW-1:0]         wr_idx_q;
  logic [N-1:0][DW-1:0]  staging_q;
  logic [N-1:0][DW-1:0]  merged;
  logic [N*DW-1:0]       frame_q;
  logic                  frame_valid_q;
  logic [7:0]            frame_cnt_q;

  logic accept;
  logic xfer;
  logic slot_free;
  logic last_sample;
  logic load_fill;
  logic load_hold;
  logic load;

  assign in_ready    = (state_q == FILL) && !in_flush;
  assign accept      = in_valid && in_ready;
  assign xfer        = frame_valid_q && frame_ready;
  // Output register can take a new frame this edge if it is empty or is
  // being emptied on the same edge.
  assign slot_free   = !frame_valid_q || frame_ready;
  assign last_sample = (wr_idx_q == LAST_IDX);

  // Last sample bypasses staging straight into the output register.
  assign load_fill = accept && last_sample && slot_free;
  // HOLD always has frame_valid_q=1, so frame_ready alone means a transfer.
  assign load_hold = (state_q == HOLD) && frame_ready;
  assign load      = load_fill || load_hold;

  // Staging contents with the incoming sample dropped into its slot.
  always_comb begin
    merged           = staging_q;
    merged[wr_idx_q] = in_data;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (accept && last_sample && !slot_free) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (frame_ready) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Staging side: write index and sample storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q  <= '0;
      staging_q <= '0;
    end else if (state_q == FILL) begin
      if (in_flush) begin
        wr_idx_q <= '0;
      end else if (accept) begin
        staging_q[wr_idx_q] <= in_data;
        // Index restarts after the last sample whether the frame goes to the
        // output now or waits in HOLD; HOLD takes no input either way.
        wr_idx_q <= last_sample ? '0 : wr_idx_q + IW'(1);
      end
    end
  end

  // Output side: frame register, valid flag and hand-off counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      if (load_fill) begin
        frame_q <= merged;
      end else if (load_hold) begin
        frame_q <= staging_q;
      end

      // A new frame loading on a transfer edge keeps valid high.
      if (load) begin
        frame_valid_q <= 1'b1;
      end else if (xfer) begin
        frame_valid_q <= 1'b0;
      end

      if (xfer) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_sort_frame_collector.sv
// -----------------------------------------------------------------------------
// tb_sort_frame_collector
// Directed scenarios followed by a randomized run. The reference keeps the
// partial frame as a sample queue and the presented/waiting frames in exp_q:
// exp_q[0] is the frame on the output, exp_q[1] (if any) is a complete frame
// waiting for the output to drain.
// -----------------------------------------------------------------------------
module tb_sort_frame_collector;
  import sort_pkg::*;

  localparam int DW = 4;
  localparam int N  = 8;
  localparam int FW = N * DW;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_flush = 1'b0;
  logic          frame_ready = 1'b0;
  logic          in_ready;
  logic          frame_valid;
  logic [FW-1:0] frame_data;
  logic [7:0]    frame_cnt;

  always #5 clk = ~clk;

  sort_frame_collector #(.DW(DW), .N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_flush   (in_flush),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_data (frame_data),
    .frame_cnt  (frame_cnt)
  );

  // ---------------- scoreboard / model ----------------
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] part_q[$];
  logic [FW-1:0] exp_q[$];
  logic [7:0]    m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] pack_part();
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < N; k++) f[k*DW +: DW] = part_q[k];
    return f;
  endfunction

  task automatic model_reset();
    part_q.delete();
    exp_q.delete();
    m_cnt = 8'd0;
  endtask

  // Apply one clock edge's worth of behaviour using the driven inputs.
  task automatic model_edge();
    bit xfer;
    bit waiting;
    xfer    = (exp_q.size() > 0) && frame_ready;
    waiting = (exp_q.size() == 2);
    if (xfer) begin
      void'(exp_q.pop_front());
      m_cnt++;
    end
    if (!waiting) begin
      if (in_flush) begin
        part_q.delete();
      end else if (in_valid) begin
        part_q.push_back(in_data);
        if (part_q.size() == N) begin
          exp_q.push_back(pack_part());
          part_q.delete();
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", in_ready, (exp_q.size() < 2) && !in_flush);
    chk("frame_valid", frame_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) chk("frame_data", frame_data, exp_q[0]);
    chk("frame_cnt", frame_cnt, m_cnt);
  endtask

  // ---------------- driver tasks ----------------
  // Called one time unit after a rising edge; checks mid-cycle.
  task automatic drive(input bit v, input logic [DW-1:0] d, input bit fl, input bit fr);
    in_valid    = v;
    in_data     = d;
    in_flush    = fl;
    frame_ready = fr;
    #3;
    check_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d, input bit fl, input bit fr);
    drive(v, d, fl, fr);
    tick();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    in_valid    = 1'b0;
    in_flush    = 1'b0;
    frame_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_frame_valid", frame_valid, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 8'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_frame_data", frame_data, '0);
    chk("rst_state", dut.state_q, FILL);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    // Single frame 1..8
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("t1_valid", frame_valid, 1'b1);
    chk("t1_data", frame_data, 32'h8765_4321);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("t1_cnt", frame_cnt, 8'd1);
    chk("t1_valid_clear", frame_valid, 1'b0);
    tick();

    // Back-to-back frames 1..8 then 8..1
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DW'(8 - i), 1'b0, 1'b1);
      chk("t2_in_ready", in_ready, 1'b1);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("t2_data", frame_data, 32'h1234_5678);
    chk("t2_cnt_mid", frame_cnt, 8'd1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t2_cnt", frame_cnt, 8'd2);
    tick();

    // Consumer stalled across two frames
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, DW'(8 - i), 1'b0, 1'b0);
    drive(1'b1, 4'd5, 1'b0, 1'b0);
    chk("t3_state_hold", dut.state_q, HOLD);
    chk("t3_in_ready", in_ready, 1'b0);
    chk("t3_data_held", frame_data, 32'h8765_4321);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("t3_data_still", frame_data, 32'h8765_4321);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t3_data2", frame_data, 32'h1234_5678);
    chk("t3_in_ready2", in_ready, 1'b1);
    chk("t3_cnt", frame_cnt, 8'd1);
    chk("t3_state_fill", dut.state_q, FILL);
    tick();

    // Flush a partial frame
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, DW'(9 + i), 1'b0, 1'b1);
    drive(1'b1, 4'hF, 1'b1, 1'b1);
    chk("t4_flush_ready", in_ready, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) step(1'b1, DW'(8 - i), 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t4_data", frame_data, 32'h1234_5678);
    tick();

    // Reset mid-frame and mid-HOLD
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, DW'(12 + i), 1'b0, 1'b1);
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t5_data", frame_data, 32'h8765_4321);
    tick();
    for (int i = 0; i < 16; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t5_hold", dut.state_q, HOLD);
    tick();
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t5_data2", frame_data, 32'h8765_4321);
    chk("t5_cnt2", frame_cnt, 8'd0);
    tick();

    // frame_cnt wrap
    do_reset();
    for (int f = 0; f < 256; f++)
      for (int k = 0; k < N; k++) step(1'b1, DW'($urandom), 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t6_wrap", frame_cnt, 8'd0);
    tick();
    for (int k = 0; k < N; k++) step(1'b1, DW'($urandom), 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t6_after_wrap", frame_cnt, 8'd1);
    tick();

    // Randomized traffic, including flushes and consumer stalls
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0,
           DW'($urandom),
           $urandom_range(0, 15) == 0,
           (c % 200 < 40) ? 1'b0 : ($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sort_frame_collector.md
Name: sort_frame_collector

Overview:
- Upstream stage of the 8-entry combinational sorter.
- Accepts a serial stream of DW-bit samples over a valid/ready handshake and assembles them into 8-sample frames.
- Presents each frame as a packed bus that drives the sorter's x1..x8 inputs.
- Double-buffered (staging plus output register), so continuous input sustains one sample per cycle when the consumer keeps up.

Parameters:
- DW, 4, sample width in bits (matches the sorter's 4-bit inputs).
- N, 8, samples per frame (fixed at 8 for the sorter; kept as a parameter for the package).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  collector can accept a sample this cycle.
- in_data  input  DW  sample value.
- in_flush  input  1  discard the partially assembled frame.
- frame_valid  output  1  complete frame held on frame_data.
- frame_ready  input  1  consumer accepts the frame.
- frame_data  output  N*DW  packed frame. Sample k (arrival order, 0-based) is at bits [k*DW +: DW]; sample 0 drives x1, sample 7 drives x8.
- frame_cnt  output  8  count of frames handed off; wraps modulo 256.

Behaviour:
- Reset (async, rst_n=0):
  - state=FILL, wr_idx=0, staging cleared.
  - frame_valid=0, frame_data=0, frame_cnt=0.
  - in_ready=1 after reset unless in_flush=1.
  - Any partial frame is lost; a reset mid-frame or mid-HOLD drops everything.
- Handshakes:
  - Input accept = in_valid && in_ready.
  - Output transfer = frame_valid && frame_ready.
  - in_ready = (state==FILL) && !in_flush. This is combinational from state and in_flush only, never from in_valid.
- States:
  - FILL: staging filling, wr_idx 0..N-1.
  - HOLD: staging complete, output register occupied.
- FILL, accept with wr_idx<N-1: write staging[wr_idx]; wr_idx+1.
- FILL, accept with wr_idx==N-1 (last sample); define slot_free = !frame_valid || frame_ready:
  - slot_free=1: frame_data <= staging with last sample merged; frame_valid <= 1; wr_idx <= 0; remain FILL.
  - slot_free=0: write last sample to staging; go HOLD.
- HOLD:
  - in_ready=0.
  - On frame_ready: frame_data <= staging, frame_valid stays 1, wr_idx <= 0, go FILL.
- Output clear: transfer with no new frame loading that edge -> frame_valid <= 0. frame_data keeps its last value (don't-care while invalid).
- frame_cnt: +1 on every output transfer; 255 -> 0.
- Latency and throughput:
  - Last sample accepted at edge k -> frame_valid=1 after edge k (visible cycle k+1) when the slot is free.
  - Back-to-back frames every N cycles with no input bubble, provided frame_ready is asserted within N cycles of frame_valid.
- frame_data stability: holds stable while frame_valid=1 && frame_ready=0.
- in_flush:
  - FILL: wr_idx <= 0. The sample is not accepted, since in_ready=0.
  - HOLD: ignored; the complete staged frame is kept.
  - Never affects the output register or frame_cnt.
- Simultaneous events:
  - Last-sample accept and output transfer on the same edge: new frame loads; frame_valid stays 1; frame_cnt increments.
  - frame_ready while frame_valid=0: no effect.

Decomposition:
- Package sort_pkg:
  - localparams SORT_DW=4, SORT_N=8.
  - state enum {FILL, HOLD} as a 1-bit encoding.
  - frame type: packed array [SORT_N-1:0][SORT_DW-1:0].
- No sub-module. The parent instantiates this block and the combinational sorter side by side.

Test Plan:
- Reset then stream 1,2,...,8 with in_valid=1 and frame_ready=1 -> frame_valid pulses the cycle after the 8th accept; frame_data=32'h87654321; frame_cnt=1.
- Two back-to-back frames (1..8, then 8..1), frame_ready=1 -> in_ready never drops; frames appear 8 cycles apart; second frame_data=32'h12345678; frame_cnt=2.
- frame_ready=0 while two frames arrive -> first frame held stable, state HOLD, in_ready=0 after 16 accepts. Raising frame_ready for one cycle loads the second frame, in_ready=1, frame_cnt=1.
- Send 5 samples, pulse in_flush, then send 8,7,...,1 -> frame_data=32'h12345678; flushed samples absent; in_ready=0 during the flush cycle.
- Assert rst_n=0 asynchronously mid-frame (after 3 samples) and mid-HOLD -> frame_valid=0, frame_cnt=0, in_ready=1 immediately. A next full frame of 8 samples is assembled from wr_idx 0.
- Issue 256 frames -> frame_cnt wraps to 0; the 257th transfer reads 1.
